// File: rtl/rob_committer.sv
// ============================================================================
// Module   : rob_committer
// Brief    : In-order commit stage with a ROB_DEPTH-entry reorder buffer and
//            NUM_FU out-of-order completion channels; flushes on redirect/trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rob_committer #(
    parameter int XLEN      = 32,
    parameter int NUM_FU    = 4,
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [4:0]               alloc_rd,
    input  logic [XLEN-1:0]          alloc_pc,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_FU-1:0]        cmpl_valid,
    input  logic [NUM_FU*TAG_W-1:0]  cmpl_tag,
    input  logic [NUM_FU*XLEN-1:0]   cmpl_result,
    input  logic [NUM_FU-1:0]        cmpl_redirect,
    input  logic [NUM_FU*XLEN-1:0]   cmpl_new_pc,
    input  logic [NUM_FU-1:0]        cmpl_trap,
    input  logic [NUM_FU*XLEN-1:0]   cmpl_cause,
    output logic                     wbrf_valid,
    input  logic                     wbrf_ready,
    output logic [4:0]               wbrf_rd,
    output logic [XLEN-1:0]          wbrf_wdata,
    output logic                     wbpcg_valid,
    input  logic                     wbpcg_ready,
    output logic [XLEN-1:0]          wbpcg_pc,
    output logic                     trap_valid,
    output logic [XLEN-1:0]          trap_pc,
    output logic [XLEN-1:0]          trap_cause,
    output logic                     flush,
    output logic [TAG_W:0]           occupancy
);

    localparam logic [0:0]     c_ST_RUN   = 1'b0;
    localparam logic [0:0]     c_ST_FLUSH = 1'b1;
    localparam logic [TAG_W:0] c_FULL     = (TAG_W+1)'(ROB_DEPTH);

    logic [0:0]           r_state;
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;
    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_redirect;
    logic [ROB_DEPTH-1:0] r_trap;
    logic [4:0]           r_rd     [ROB_DEPTH];
    logic [XLEN-1:0]      r_pc     [ROB_DEPTH];
    logic [XLEN-1:0]      r_result [ROB_DEPTH];
    logic [XLEN-1:0]      r_new_pc [ROB_DEPTH];
    logic [XLEN-1:0]      r_cause  [ROB_DEPTH];

    logic [ROB_DEPTH-1:0] w_match;
    logic [ROB_DEPTH-1:0] w_hit;
    logic [ROB_DEPTH-1:0] w_c_redir;
    logic [ROB_DEPTH-1:0] w_c_trap;
    logic [XLEN-1:0]      w_c_result [ROB_DEPTH];
    logic [XLEN-1:0]      w_c_new_pc [ROB_DEPTH];
    logic [XLEN-1:0]      w_c_cause  [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] w_busy_nxt;
    logic [ROB_DEPTH-1:0] w_done_nxt;
    logic                 w_h_redir;
    logic                 w_h_trap;
    logic                 w_commit;
    logic                 w_flush_commit;
    logic                 w_alloc;

    // Channels scanned high-to-low so the lowest index is the last writer and wins.
    always_comb begin
        w_match   = '0;
        w_c_redir = '0;
        w_c_trap  = '0;
        for (int e = 0; e < ROB_DEPTH; e++) begin
            w_c_result[e] = '0;
            w_c_new_pc[e] = '0;
            w_c_cause[e]  = '0;
            for (int f = NUM_FU - 1; f >= 0; f--) begin
                if (cmpl_valid[f] && (cmpl_tag[f*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    w_match[e]    = 1'b1;
                    w_c_result[e] = cmpl_result[f*XLEN +: XLEN];
                    w_c_new_pc[e] = cmpl_new_pc[f*XLEN +: XLEN];
                    w_c_cause[e]  = cmpl_cause[f*XLEN +: XLEN];
                    w_c_redir[e]  = cmpl_redirect[f];
                    w_c_trap[e]   = cmpl_trap[f];
                end
            end
        end
    end

    assign w_hit = w_match & r_busy & ~r_done & {ROB_DEPTH{r_state == c_ST_RUN}};

    assign w_h_redir      = r_redirect[r_head];
    assign w_h_trap       = r_trap[r_head];
    assign w_commit       = (r_count != '0) && r_done[r_head] && wbrf_ready &&
                            (!(w_h_redir || w_h_trap) || wbpcg_ready);
    assign w_flush_commit = w_commit && (w_h_redir || w_h_trap);
    assign w_alloc        = alloc_valid && alloc_ready;

    always_comb begin
        w_busy_nxt = r_busy;
        w_done_nxt = r_done | w_hit;
        if (w_commit) begin
            w_busy_nxt[r_head] = 1'b0;
            w_done_nxt[r_head] = 1'b0;
        end
        if (w_alloc) begin
            w_busy_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_done  <= '0;
        end else if (w_flush_commit) begin
            // Everything younger than the head is discarded; both pointers restart past it.
            r_state <= c_ST_FLUSH;
            r_head  <= r_head + 1'b1;
            r_tail  <= r_head + 1'b1;
            r_count <= '0;
            r_busy  <= '0;
            r_done  <= '0;
        end else begin
            r_state <= c_ST_RUN;
            r_head  <= r_head + TAG_W'(w_commit);
            r_tail  <= r_tail + TAG_W'(w_alloc);
            r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Payload storage is qualified by busy/done, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ROB_DEPTH; e++) begin
            if (w_alloc && (r_tail == TAG_W'(e))) begin
                r_rd[e] <= alloc_rd;
                r_pc[e] <= alloc_pc;
            end
            if (w_hit[e]) begin
                r_result[e]   <= w_c_result[e];
                r_new_pc[e]   <= w_c_new_pc[e];
                r_cause[e]    <= w_c_cause[e];
                r_redirect[e] <= w_c_redir[e];
                r_trap[e]     <= w_c_trap[e];
            end
        end
    end

    assign alloc_ready = (r_count != c_FULL) && (r_state == c_ST_RUN) && !w_flush_commit;
    assign alloc_tag   = r_tail;
    assign wbrf_valid  = w_commit;
    assign wbrf_rd     = (w_commit && !w_h_trap) ? r_rd[r_head] : 5'd0;
    assign wbrf_wdata  = w_commit ? r_result[r_head] : '0;
    assign wbpcg_valid = w_flush_commit;
    assign wbpcg_pc    = (w_flush_commit && !w_h_trap) ? r_new_pc[r_head] : '0;
    assign trap_valid  = w_commit && w_h_trap;
    assign trap_pc     = (w_commit && w_h_trap) ? r_pc[r_head] : '0;
    assign trap_cause  = (w_commit && w_h_trap) ? r_cause[r_head] : '0;
    assign flush       = (r_state == c_ST_FLUSH);
    assign occupancy   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rob_committer.sv
// ============================================================================
// Module   : tb_rob_committer
// Brief    : Directed and random checks of rob_committer against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rob_committer;

    localparam int XLEN   = 32;
    localparam int NUM_FU = 4;
    localparam int DEPTH  = 8;
    localparam int TW     = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [4:0]             alloc_rd;
    logic [XLEN-1:0]        alloc_pc;
    logic [TW-1:0]          alloc_tag;
    logic [NUM_FU-1:0]      cmpl_valid;
    logic [NUM_FU*TW-1:0]   cmpl_tag;
    logic [NUM_FU*XLEN-1:0] cmpl_result;
    logic [NUM_FU-1:0]      cmpl_redirect;
    logic [NUM_FU*XLEN-1:0] cmpl_new_pc;
    logic [NUM_FU-1:0]      cmpl_trap;
    logic [NUM_FU*XLEN-1:0] cmpl_cause;
    logic                   wbrf_valid;
    logic                   wbrf_ready;
    logic [4:0]             wbrf_rd;
    logic [XLEN-1:0]        wbrf_wdata;
    logic                   wbpcg_valid;
    logic                   wbpcg_ready;
    logic [XLEN-1:0]        wbpcg_pc;
    logic                   trap_valid;
    logic [XLEN-1:0]        trap_pc;
    logic [XLEN-1:0]        trap_cause;
    logic                   flush;
    logic [TW:0]            occupancy;

    always #5 clk = ~clk;

    rob_committer #(.XLEN(XLEN), .NUM_FU(NUM_FU), .ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_result(cmpl_result),
        .cmpl_redirect(cmpl_redirect), .cmpl_new_pc(cmpl_new_pc),
        .cmpl_trap(cmpl_trap), .cmpl_cause(cmpl_cause),
        .wbrf_valid(wbrf_valid), .wbrf_ready(wbrf_ready), .wbrf_rd(wbrf_rd),
        .wbrf_wdata(wbrf_wdata),
        .wbpcg_valid(wbpcg_valid), .wbpcg_ready(wbpcg_ready), .wbpcg_pc(wbpcg_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .flush(flush), .occupancy(occupancy)
    );

    // Reference model: in-flight instructions in program order.
    typedef struct {
        logic [TW-1:0]   tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] cause;
        bit              done;
        bit              redir;
        bit              trap;
    } ent_t;

    ent_t            q[$];
    logic [TW-1:0]   m_tail;
    bit              m_flush;
    bit              e_commit, e_fl, e_ready;
    ent_t            e_head;

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [4:0]      log_rd[$];
    logic [XLEN-1:0] log_wd[$];
    int              n_flush_seen;
    logic [XLEN-1:0] last_pcg;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        log_rd.delete();
        log_wd.delete();
        n_flush_seen = 0;
        last_pcg     = '0;
    endtask

    task automatic predict();
        e_commit = 1'b0;
        e_fl     = 1'b0;
        if (q.size() > 0) begin
            e_head   = q[0];
            e_commit = e_head.done && wbrf_ready &&
                       (!(e_head.redir || e_head.trap) || wbpcg_ready);
            e_fl     = e_commit && (e_head.redir || e_head.trap);
        end
        e_ready = (q.size() < DEPTH) && !m_flush && !e_fl;
    endtask

    task automatic check_outputs();
        chk("alloc_ready", XLEN'(alloc_ready), XLEN'(e_ready));
        chk("alloc_tag",   XLEN'(alloc_tag),   XLEN'(m_tail));
        chk("occupancy",   XLEN'(occupancy),   XLEN'(q.size()));
        chk("wbrf_valid",  XLEN'(wbrf_valid),  XLEN'(e_commit));
        chk("wbpcg_valid", XLEN'(wbpcg_valid), XLEN'(e_fl));
        chk("trap_valid",  XLEN'(trap_valid),  XLEN'(e_commit && e_head.trap));
        chk("flush",       XLEN'(flush),       XLEN'(m_flush));
        if (e_commit) begin
            chk("wbrf_rd",    XLEN'(wbrf_rd), e_head.trap ? '0 : XLEN'(e_head.rd));
            chk("wbrf_wdata", wbrf_wdata, e_head.res);
        end
        if (e_fl)
            chk("wbpcg_pc", wbpcg_pc, e_head.trap ? '0 : e_head.npc);
        if (e_commit && e_head.trap) begin
            chk("trap_pc",    trap_pc,    e_head.pc);
            chk("trap_cause", trap_cause, e_head.cause);
        end
    endtask

    task automatic update_model();
        ent_t t;
        bit   was_flush = m_flush;
        if (!was_flush) begin
            for (int ch = 0; ch < NUM_FU; ch++) begin
                if (cmpl_valid[ch]) begin
                    for (int i = 0; i < q.size(); i++) begin
                        t = q[i];
                        if (t.tag == cmpl_tag[ch*TW +: TW] && !t.done) begin
                            t.done  = 1'b1;
                            t.res   = cmpl_result[ch*XLEN +: XLEN];
                            t.npc   = cmpl_new_pc[ch*XLEN +: XLEN];
                            t.cause = cmpl_cause[ch*XLEN +: XLEN];
                            t.redir = cmpl_redirect[ch];
                            t.trap  = cmpl_trap[ch];
                            q[i]    = t;
                        end
                    end
                end
            end
        end
        if (e_commit) begin
            t = q.pop_front();
            if (e_fl) begin
                q.delete();
                m_tail = t.tag + 3'd1;
            end
        end
        if (alloc_valid && e_ready) begin
            t = '{tag: m_tail, rd: alloc_rd, pc: alloc_pc, res: '0, npc: '0, cause: '0,
                  done: 1'b0, redir: 1'b0, trap: 1'b0};
            q.push_back(t);
            m_tail = m_tail + 3'd1;
        end
        m_flush = e_fl;
    endtask

    task automatic tick();
        #1;
        predict();
        check_outputs();
        if (wbrf_valid) begin
            log_rd.push_back(wbrf_rd);
            log_wd.push_back(wbrf_wdata);
        end
        if (flush) n_flush_seen++;
        if (wbpcg_valid) last_pcg = wbpcg_pc;
        @(posedge clk);
        update_model();
        @(negedge clk);
        alloc_valid   = 1'b0;
        cmpl_valid    = '0;
        cmpl_redirect = '0;
        cmpl_trap     = '0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [XLEN-1:0] pc);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_pc    = pc;
    endtask

    task automatic do_cmpl(input int ch, input logic [TW-1:0] tag, input logic [XLEN-1:0] res,
                           input bit redir, input logic [XLEN-1:0] npc,
                           input bit trap, input logic [XLEN-1:0] cause);
        cmpl_valid[ch]                = 1'b1;
        cmpl_tag[ch*TW +: TW]         = tag;
        cmpl_result[ch*XLEN +: XLEN]  = res;
        cmpl_redirect[ch]             = redir;
        cmpl_new_pc[ch*XLEN +: XLEN]  = npc;
        cmpl_trap[ch]                 = trap;
        cmpl_cause[ch*XLEN +: XLEN]   = cause;
    endtask

    // Raises rst wherever the caller stands in the cycle; outputs must react without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        m_tail  = '0;
        m_flush = 1'b0;
        chk("rst_alloc_ready", XLEN'(alloc_ready), 32'd1);
        chk("rst_alloc_tag",   XLEN'(alloc_tag),   32'd0);
        chk("rst_occupancy",   XLEN'(occupancy),   32'd0);
        chk("rst_wbrf_valid",  XLEN'(wbrf_valid),  32'd0);
        chk("rst_wbpcg_valid", XLEN'(wbpcg_valid), 32'd0);
        chk("rst_trap_valid",  XLEN'(trap_valid),  32'd0);
        chk("rst_flush",       XLEN'(flush),       32'd0);
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        alloc_valid   = 1'b0;
        cmpl_valid    = '0;
        cmpl_redirect = '0;
        cmpl_trap     = '0;
        clear_logs();
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
        cmpl_valid = '0; cmpl_tag = '0; cmpl_result = '0; cmpl_redirect = '0;
        cmpl_new_pc = '0; cmpl_trap = '0; cmpl_cause = '0;
        wbrf_ready = 1'b1; wbpcg_ready = 1'b1;
        do_reset();

        // Out-of-order completion, in-order commit
        for (int i = 1; i <= 3; i++) begin
            do_alloc(5'(i), 32'h1000 + 32'(4*i));
            tick();
        end
        do_cmpl(0, 3'd2, 32'hA, 0, 0, 0, 0);
        tick();
        tick();
        chk("t1_no_early_commit", XLEN'(log_rd.size()), 32'd0);
        do_cmpl(1, 3'd0, 32'hB, 0, 0, 0, 0);
        tick();
        do_cmpl(2, 3'd1, 32'hC, 0, 0, 0, 0);
        repeat (5) tick();
        chk("t1_commit_count", XLEN'(log_rd.size()), 32'd3);
        if (log_rd.size() == 3) begin
            chk("t1_rd0", XLEN'(log_rd[0]), 32'd1); chk("t1_wd0", log_wd[0], 32'hB);
            chk("t1_rd1", XLEN'(log_rd[1]), 32'd2); chk("t1_wd1", log_wd[1], 32'hC);
            chk("t1_rd2", XLEN'(log_rd[2]), 32'd3); chk("t1_wd2", log_wd[2], 32'hA);
        end

        // Full ROB, release one slot, wrap the tail
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(5'(i + 1), 32'(i));
            tick();
        end
        #1;
        chk("t2_full_ready", XLEN'(alloc_ready), 32'd0);
        chk("t2_full_occ",   XLEN'(occupancy),   32'd8);
        do_alloc(5'd9, 32'h99);
        tick();
        do_cmpl(0, 3'd0, 32'h50, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        chk("t2_ready_after_commit", XLEN'(alloc_ready), 32'd1);
        do_cmpl(0, 3'd1, 32'h51, 0, 0, 0, 0);
        do_cmpl(1, 3'd2, 32'h52, 0, 0, 0, 0);
        do_cmpl(2, 3'd3, 32'h53, 0, 0, 0, 0);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            do_alloc(5'(20 + i), 32'h200 + 32'(i));
            #1;
            chk("t2_wrap_tag", XLEN'(alloc_tag), 32'(i));
            tick();
        end

        // Branch redirect flushes younger completed work
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            do_alloc(5'(i), 32'h300 + 32'(4*i));
            tick();
        end
        do_cmpl(0, 3'd2, 32'h22, 0, 0, 0, 0);
        do_cmpl(1, 3'd3, 32'h33, 0, 0, 0, 0);
        do_cmpl(2, 3'd0, 32'h00, 0, 0, 0, 0);
        do_cmpl(3, 3'd1, 32'h11, 1, 32'h80, 0, 0);
        repeat (5) tick();
        chk("t3_commits",  XLEN'(log_rd.size()), 32'd2);
        chk("t3_flushes",  XLEN'(n_flush_seen),  32'd1);
        chk("t3_pcg_pc",   last_pcg,             32'h80);
        if (log_rd.size() == 2)
            chk("t3_last_rd", XLEN'(log_rd[1]), 32'd2);
        #1;
        chk("t3_occ", XLEN'(occupancy), 32'd0);

        // Trap stalled by PC generator back-pressure
        do_reset();
        do_alloc(5'd5, 32'h100);
        tick();
        do_cmpl(0, 3'd0, 32'h77, 0, 0, 1, 32'd2);
        wbpcg_ready = 1'b0;
        repeat (4) tick();
        chk("t4_stalled", XLEN'(log_rd.size()), 32'd0);
        wbpcg_ready = 1'b1;
        #1;
        chk("t4_trap_valid", XLEN'(trap_valid), 32'd1);
        chk("t4_trap_cause", trap_cause,        32'd2);
        chk("t4_trap_pc",    trap_pc,           32'h100);
        chk("t4_wbrf_rd",    XLEN'(wbrf_rd),    32'd0);
        repeat (3) tick();

        // Same-tag collision and completion to an idle tag
        do_reset();
        do_alloc(5'd7, 32'h400);
        tick();
        do_cmpl(0, 3'd0, 32'h11, 0, 0, 0, 0);
        do_cmpl(2, 3'd0, 32'h22, 0, 0, 0, 0);
        tick();
        tick();
        chk("t5_count", XLEN'(log_wd.size()), 32'd1);
        if (log_wd.size() == 1)
            chk("t5_low_channel_wins", log_wd[0], 32'h11);
        do_alloc(5'd8, 32'h404);
        tick();
        do_cmpl(1, 3'd5, 32'h55, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t5_idle_tag_ignored", XLEN'(log_wd.size()), 32'd1);
        do_cmpl(3, 3'd1, 32'h66, 0, 0, 0, 0);
        repeat (2) tick();

        // Asynchronous reset with work in flight and a commit pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_alloc(5'(i + 1), 32'(i));
            tick();
        end
        do_cmpl(0, 3'd0, 32'h12, 0, 0, 0, 0);
        tick();
        #2;
        do_reset();
        tick();

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(599) == 0) do_reset();
            if ($urandom_range(1) == 1) do_alloc(5'($urandom_range(31)), $urandom);
            wbrf_ready  = ($urandom_range(9) < 8);
            wbpcg_ready = ($urandom_range(9) < 7);
            for (int ch = 0; ch < NUM_FU; ch++) begin
                if ($urandom_range(9) < 4) begin
                    logic [TW-1:0] tg;
                    tg = 3'($urandom_range(7));
                    if (q.size() > 0 && $urandom_range(9) < 7)
                        tg = q[$urandom_range(q.size() - 1)].tag;
                    do_cmpl(ch, tg, $urandom, ($urandom_range(19) == 0), $urandom,
                            ($urandom_range(39) == 0), 32'($urandom_range(15)));
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
